// File: rtl/viterbi_decoder.sv
// K=7 rate-1/2 hard-decision Viterbi decoder (generators 133/171 octal) with per-bit erasures.
// All 64 add-compare-select units update in one cycle; survivors use register exchange.
module viterbi_decoder #(
    parameter int TB_DEPTH = 32,
    parameter int PM_W     = 8
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] data_in,
    input  logic [1:0] erase,
    output logic       data_out,
    output logic       valid_out
);
    localparam int unsigned       NS       = 64;
    localparam int                FILL_W   = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0]   NORM     = {2'b01, {(PM_W-2){1'b0}}};
    localparam logic [PM_W-1:0]   PM_INIT  = PM_W'(32);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH);

    logic [PM_W-1:0]     pm_q   [NS];
    logic [PM_W-1:0]     pm_d   [NS];
    logic [TB_DEPTH-1:0] sv_q   [NS];
    logic [TB_DEPTH-1:0] sv_d   [NS];
    logic [PM_W-1:0]     acs_pm [NS];
    logic                dec    [NS];
    logic                all_ge;
    logic [5:0]          best;
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   fill_d;
    logic                data_q;
    logic                valid_q;

    // Hamming distance between the received pair and the branch label, skipping erased bits.
    function automatic logic [PM_W-1:0] branch_metric(
        input logic [5:0] p,
        input logic       d,
        input logic [1:0] rx,
        input logic [1:0] er
    );
        logic           ea;
        logic           eb;
        logic [PM_W-1:0] r;
        ea = d ^ p[1] ^ p[2] ^ p[4] ^ p[5];
        eb = d ^ p[0] ^ p[1] ^ p[2] ^ p[5];
        r  = '0;
        if (!er[0] && (rx[0] != ea)) r = r + PM_W'(1);
        if (!er[1] && (rx[1] != eb)) r = r + PM_W'(1);
        return r;
    endfunction

    always_comb begin
        logic [5:0]      st;
        logic [5:0]      p0;
        logic [5:0]      p1;
        logic [PM_W-1:0] c0;
        logic [PM_W-1:0] c1;
        st     = '0;
        p0     = '0;
        p1     = '0;
        c0     = '0;
        c1     = '0;
        all_ge = 1'b1;
        for (int unsigned n = 0; n < NS; n++) begin
            st        = 6'(n);
            p0        = {1'b0, st[5:1]};
            p1        = {1'b1, st[5:1]};
            c0        = pm_q[p0] + branch_metric(p0, st[0], data_in, erase);
            c1        = pm_q[p1] + branch_metric(p1, st[0], data_in, erase);
            dec[n]    = (c1 < c0);
            acs_pm[n] = dec[n] ? c1 : c0;
            if (acs_pm[n] < NORM) all_ge = 1'b0;
        end
    end

    // The decision bit is the MSB of the selected predecessor, so it indexes the survivor directly.
    always_comb begin
        logic [5:0] st;
        st = '0;
        for (int unsigned n = 0; n < NS; n++) begin
            st      = 6'(n);
            pm_d[n] = all_ge ? (acs_pm[n] - NORM) : acs_pm[n];
            sv_d[n] = {sv_q[{dec[n], st[5:1]}][TB_DEPTH-2:0], st[0]};
        end
    end

    always_comb begin
        logic [PM_W-1:0] bmin;
        best = '0;
        bmin = pm_q[0];
        for (int unsigned n = 1; n < NS; n++) begin
            if (pm_q[n] < bmin) begin
                bmin = pm_q[n];
                best = 6'(n);
            end
        end
    end

    always_comb begin
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int unsigned n = 0; n < NS; n++) begin
                pm_q[n] <= (n == 0) ? '0 : PM_INIT;
                sv_q[n] <= '0;
            end
            fill_q  <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (en) begin
                pm_q    <= pm_d;
                sv_q    <= sv_d;
                fill_q  <= fill_d;
                valid_q <= (fill_q == FILL_MAX);
                data_q  <= sv_q[best][TB_DEPTH-1];
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: a golden convolutional encoder feeds the DUT and the
// source bits themselves are the expected decoded stream, popped by an independent monitor.
module tb_viterbi_decoder;
    localparam int TB  = 32;
    localparam int PMW = 8;

    logic       Clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       en      = 1'b0;
    logic [1:0] data_in = '0;
    logic [1:0] erase   = '0;
    logic       data_out;
    logic       valid_out;

    int         checks    = 0;
    int         errors    = 0;
    int         acc       = 0;
    bit         edge_en   = 1'b0;
    bit         sb_on     = 1'b1;
    bit         gaps      = 1'b0;
    logic       prev_data = 1'b0;
    bit         exp_q[$];
    logic [5:0] enc_s     = '0;

    viterbi_decoder #(.TB_DEPTH(TB), .PM_W(PMW)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .en        (en),
        .data_in   (data_in),
        .erase     (erase),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    always #5 Clk = ~Clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Golden encoder: returns {B,A} for state s (s[0] newest) and input bit d.
    function automatic logic [1:0] encode(input logic [5:0] s, input logic d);
        return {d ^ s[0] ^ s[1] ^ s[2] ^ s[5], d ^ s[1] ^ s[2] ^ s[4] ^ s[5]};
    endfunction

    // One clock: account for the pair the DUT just sampled, then drive the next one.
    task automatic step(input logic e, input logic [1:0] d, input logic [1:0] er);
        @(posedge Clk);
        #2;
        edge_en = en && !reset;
        if (edge_en) acc++;
        en      = e;
        data_in = d;
        erase   = er;
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 2'b00);
        reset     = 1'b1;
        acc       = 0;
        edge_en   = 1'b0;
        prev_data = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_pm0", dut.pm_q[0], 0);
        chk("rst_pm1", dut.pm_q[1], 32);
        chk("rst_pm63", dut.pm_q[63], 32);
        chk("rst_sv0", dut.sv_q[0], 0);
        chk("rst_sv63", dut.sv_q[63], 0);
        chk("rst_fill", dut.fill_q, 0);
        repeat (2) step(1'b0, 2'b00, 2'b00);
        reset = 1'b0;
    endtask

    task automatic send(input logic d, input logic [1:0] er, input logic [1:0] flip);
        logic [1:0] p;
        int         g;
        g = 0;
        if (gaps) begin
            while (g < 4 && $urandom_range(1, 0) == 1) begin
                step(1'b0, 2'($urandom), 2'($urandom));
                g++;
            end
        end
        p     = (encode(enc_s, d) ^ flip) & ~er;
        enc_s = {enc_s[4:0], d};
        exp_q.push_back(d);
        step(1'b1, p, er);
    endtask

    task automatic run_stream(input bit bits[$], input bit punct, input bit errs);
        logic [1:0] flip;
        logic [1:0] er;
        int         k;
        do_reset();
        enc_s = '0;
        for (int i = 0; i < bits.size(); i++) begin
            k    = i + 1;
            flip = 2'b00;
            if (errs && (k == 20 || k == 120)) flip = 2'b01;
            if (errs && k == 60)               flip = 2'b10;
            er = 2'b00;
            if (punct && (i % 3 == 1)) er = 2'b10;
            if (punct && (i % 3 == 2)) er = 2'b01;
            send(bits[i], er, flip);
        end
        repeat (3) step(1'b0, 2'b00, 2'b00);
        chk("undecoded_left", exp_q.size(), TB);
        exp_q.delete();
    endtask

    always @(negedge Clk) begin
        int mn;
        int mx;
        chk("valid_out", valid_out, (edge_en && acc > TB) ? 1 : 0);
        if (valid_out === 1'b1 && sb_on) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got valid_out=1 expected no decoded bit pending (t=%0t)", $time);
            end else begin
                chk("data_out", data_out, exp_q.pop_front());
            end
        end
        if (!edge_en) chk("data_hold", data_out, prev_data);
        prev_data = data_out;
        mn = 1 << 30;
        mx = 0;
        for (int i = 0; i < 64; i++) begin
            if (int'(dut.pm_q[i]) < mn) mn = int'(dut.pm_q[i]);
            if (int'(dut.pm_q[i]) > mx) mx = int'(dut.pm_q[i]);
        end
        checks++;
        assert (mx - mn <= 64 && mn < 64)
        else begin
            errors++;
            $display("FAIL pm_range: got min %0d max %0d expected min<64 and max-min<=64 (t=%0t)", mn, mx, $time);
        end
    end

    initial begin
        bit s[$];
        bit f[$];
        bit z[$];

        do_reset();

        repeat (100) z.push_back(1'b0);
        run_stream(z, 1'b0, 1'b0);

        z.delete();
        z.push_back(1'b1);
        repeat (63) z.push_back(1'b0);
        run_stream(z, 1'b0, 1'b0);

        repeat (200) s.push_back(1'($urandom));
        repeat (6 + TB) s.push_back(1'b0);
        run_stream(s, 1'b0, 1'b1);
        run_stream(s, 1'b1, 1'b0);
        gaps = 1'b1;
        run_stream(s, 1'b0, 1'b1);
        gaps = 1'b0;

        // Abandon a stream after pair 50; the next run_stream pulses reset and starts fresh.
        do_reset();
        enc_s = '0;
        for (int i = 0; i < 50; i++) send(s[i], 2'b00, 2'b00);
        repeat (120) f.push_back(1'($urandom));
        repeat (6 + TB) f.push_back(1'b0);
        run_stream(f, 1'b0, 1'b0);

        do_reset();
        sb_on = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            step(1'b1, 2'($urandom), ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00);
        end
        repeat (3) step(1'b0, 2'b00, 2'b00);
        chk("fill_saturated", dut.fill_q, TB);
        sb_on = 1'b1;
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
